tb_spi_sram: RTL and testbench



---
 rtl/tb_spi_sram_if.sv | 24 ++
 rtl/tb_spi_sram.sv | 231 +++++++++++++++++++++++
 tb/tb_tb_spi_sram.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tb_spi_sram_if.sv
// SPI pins plus write-observation and mode outputs of the SPI SRAM bench model.
// The slave modport is the memory model's view of the bus.
interface tb_spi_sram_if #(
   parameter int unsigned AW = 8
);
   logic          spi_clk;
   logic          spi_mosi;
   logic          spi_ce;
   logic          spi_miso;
   logic          wr_strobe;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [1:0]    mode;

   modport slave (
      input  spi_clk, spi_mosi, spi_ce,
      output spi_miso, wr_strobe, wr_addr, wr_data, mode
   );

   modport master (
      output spi_clk, spi_mosi, spi_ce,
      input  spi_miso, wr_strobe, wr_addr, wr_data, mode
   );
endinterface

// File: rtl/tb_spi_sram.sv
// Clocked model of a 23LCxxxx-style SPI SRAM (READ/WRITE/RDMR/WRMR, byte/page/sequential modes).
// The SPI pins are oversampled on clk; each spi_clk phase must last at least 3 clk.
module tb_spi_sram #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned ADDR_BYTES = 3,
   parameter int unsigned PAGE_BYTES = 32,
   parameter logic [1:0]  INIT_MODE  = 2'b01
) (
   input logic          clk,
   input logic          rst_n,
   tb_spi_sram_if.slave bus
);
   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned ADDR_BITS = ADDR_BYTES * 8;
   localparam logic [AW-1:0] PageMask = AW'(PAGE_BYTES - 1);
   localparam logic [1:0] ModeSeq  = 2'b01;
   localparam logic [1:0] ModePage = 2'b10;

   typedef enum logic [2:0] {
      StCmd, StAddr, StRd, StWr, StRdmr, StWrmr, StIgnore
   } state_e;

   function automatic logic [DEPTH-1:0][7:0] mem_init();
      logic [DEPTH-1:0][7:0] m;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         m[i] = 8'(i + 1);
      end
      return m;
   endfunction

   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] m);
      logic [AW-1:0] inc;
      inc = a + AW'(1);
      case (m)
         ModeSeq:  return inc;
         ModePage: return (a & ~PageMask) | (inc & PageMask);
         default:  return a;
      endcase
   endfunction

   // Power-up image only; reset deliberately leaves the contents alone.
   logic [DEPTH-1:0][7:0] mem_q = mem_init();

   logic          sclk_q, sclk_prev_q, mosi_q, ce_q;
   logic          sclk_rise, sclk_fall;
   state_e        state_q, state_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [6:0]    rx_q, rx_d;
   logic [7:0]    rx_next;
   logic          is_read_q, is_read_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          miso_q, miso_d;
   logic [1:0]    mode_q, mode_d;
   logic          wr_strobe_q, wr_strobe_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          mem_we;

   assign sclk_rise = sclk_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_q & sclk_prev_q;
   assign rx_next   = {rx_q, mosi_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_q      <= 1'b0;
         sclk_prev_q <= 1'b0;
         mosi_q      <= 1'b0;
         ce_q        <= 1'b1;
         state_q     <= StCmd;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         is_read_q   <= 1'b0;
         addr_q      <= '0;
         shreg_q     <= '0;
         miso_q      <= 1'b0;
         mode_q      <= INIT_MODE;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         sclk_q      <= bus.spi_clk;
         sclk_prev_q <= sclk_q;
         mosi_q      <= bus.spi_mosi;
         ce_q        <= bus.spi_ce;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         is_read_q   <= is_read_d;
         addr_q      <= addr_d;
         shreg_q     <= shreg_d;
         miso_q      <= miso_d;
         mode_q      <= mode_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem_q[addr_q] <= rx_next;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      is_read_d   = is_read_q;
      addr_d      = addr_q;
      shreg_d     = shreg_q;
      miso_d      = miso_q;
      mode_d      = mode_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      mem_we      = 1'b0;

      // Deselect wins over any edge seen in the same clk.
      if (ce_q) begin
         state_d   = StCmd;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
      end else begin
         unique case (state_q)
            StCmd: begin
               miso_d = 1'b0;
               if (sclk_rise) begin
                  rx_d      = rx_next[6:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     is_read_d = (rx_next == 8'h03);
                     addr_d    = '0;
                     shreg_d   = {mode_q, 6'b0};
                     case (rx_next)
                        8'h02, 8'h03: state_d = StAddr;
                        8'h05:        state_d = StRdmr;
                        8'h01:        state_d = StWrmr;
                        default:      state_d = StIgnore;
                     endcase
                  end
               end
            end
            StAddr: begin
               miso_d = 1'b0;
               if (sclk_rise) begin
                  // Shifting into an AW-bit register keeps the address modulo DEPTH.
                  addr_d    = {addr_q[AW-2:0], mosi_q};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                     bit_cnt_d = '0;
                     if (is_read_q) begin
                        shreg_d = mem_q[addr_d];
                        state_d = StRd;
                     end else begin
                        state_d = StWr;
                     end
                  end
               end
            end
            StRd: begin
               if (sclk_fall) begin
                  miso_d    = shreg_q[7];
                  shreg_d   = {shreg_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     addr_d    = next_addr(addr_q, mode_q);
                     shreg_d   = mem_q[addr_d];
                  end
               end
            end
            StRdmr: begin
               if (sclk_fall) begin
                  miso_d    = shreg_q[7];
                  shreg_d   = {shreg_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     shreg_d   = {mode_q, 6'b0};
                  end
               end
            end
            StWr: begin
               miso_d = 1'b0;
               if (sclk_rise) begin
                  rx_d      = rx_next[6:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d   = '0;
                     mem_we      = 1'b1;
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = addr_q;
                     wr_data_d   = rx_next;
                     addr_d      = next_addr(addr_q, mode_q);
                  end
               end
            end
            StWrmr: begin
               miso_d = 1'b0;
               if (sclk_rise) begin
                  rx_d      = rx_next[6:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     if (rx_next[7:6] != 2'b11) begin
                        mode_d = rx_next[7:6];
                     end
                     state_d = StIgnore;
                  end
               end
            end
            StIgnore: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = StCmd;
            end
         endcase
      end
   end

   assign bus.spi_miso  = miso_q;
   assign bus.wr_strobe = wr_strobe_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.mode      = mode_q;

endmodule

// File: tb/tb_tb_spi_sram.sv
// Bench for tb_spi_sram: bit-banged SPI master, byte-array reference memory, random
// write/read rounds across all addressing modes.
module tb_tb_spi_sram;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   tb_spi_sram_if #(.AW(8)) bus ();

   tb_spi_sram dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mem_m [256];
   logic [1:0]  mode_m;
   logic [15:0] strobe_q [$];
   logic [7:0]  wbuf [8];
   logic [7:0]  last_rx;

   always @(negedge clk) begin
      if (bus.wr_strobe === 1'b1) strobe_q.push_back({bus.wr_addr, bus.wr_data});
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int adv(input int a);
      case (mode_m)
         2'b01:   return (a + 1) % 256;
         2'b10:   return (a / 32) * 32 + (a + 1) % 32;
         default: return a;
      endcase
   endfunction

   task automatic spi_bit(input logic b);
      bus.spi_mosi = b;
      tick(4);
      last_rx = {last_rx[6:0], bus.spi_miso};
      bus.spi_clk = 1'b1;
      tick(4);
      bus.spi_clk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic start_x();
      bus.spi_ce = 1'b0;
      tick(4);
   endtask

   task automatic end_x();
      tick(4);
      bus.spi_ce = 1'b1;
      tick(4);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input int a);
      spi_byte(cmd);
      spi_byte(8'h00);
      spi_byte(8'h00);
      spi_byte(8'(a));
   endtask

   task automatic do_write(input int a, input int n);
      int aa;
      strobe_q.delete();
      start_x();
      send_hdr(8'h02, a);
      for (int i = 0; i < n; i++) spi_byte(wbuf[i]);
      end_x();
      chk("wr_count", 32'(strobe_q.size()), 32'(n));
      aa = a;
      for (int i = 0; i < n; i++) begin
         chk("wr_strobe", (i < strobe_q.size()) ? 32'(strobe_q[i]) : 32'hDEAD_BEEF,
             {16'h0, 8'(aa), wbuf[i]});
         mem_m[aa] = wbuf[i];
         aa = adv(aa);
      end
   endtask

   task automatic do_read(input int a, input int n, input string tag);
      int aa;
      aa = a;
      start_x();
      send_hdr(8'h03, a);
      for (int i = 0; i < n; i++) begin
         spi_byte(8'h00);
         chk(tag, 32'(last_rx), 32'(mem_m[aa]));
         aa = adv(aa);
      end
      end_x();
   endtask

   task automatic do_wrmr(input logic [7:0] b);
      start_x();
      spi_byte(8'h01);
      spi_byte(b);
      end_x();
      if (b[7:6] != 2'b11) mode_m = b[7:6];
      chk("mode", 32'(bus.mode), 32'(mode_m));
   endtask

   initial begin
      int a, n, m;
      for (int i = 0; i < 256; i++) mem_m[i] = 8'(i + 1);
      mode_m       = 2'b01;
      bus.spi_clk  = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.spi_ce   = 1'b1;
      rst_n        = 1'b0;
      tick(3);
      chk("rst_miso", 32'(bus.spi_miso), 32'h0);
      chk("rst_strobe", 32'(bus.wr_strobe), 32'h0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'h0);
      chk("rst_mode", 32'(bus.mode), 32'h1);
      rst_n = 1'b1;
      tick(2);

      do_read(8'h05, 3, "rd_init");

      wbuf[0] = 8'hAA;
      wbuf[1] = 8'h55;
      do_write(8'h10, 2);
      do_read(8'h10, 2, "rd_after_wr");

      do_wrmr(8'h80);
      wbuf[0] = 8'h11;
      wbuf[1] = 8'h22;
      do_write(8'h1F, 2);
      do_read(8'h1F, 2, "rd_page_wrap");
      start_x();
      spi_byte(8'h05);
      spi_byte(8'h00);
      chk("rdmr_0", 32'(last_rx), 32'h80);
      spi_byte(8'h00);
      chk("rdmr_1", 32'(last_rx), 32'h80);
      end_x();

      do_wrmr(8'h40);
      do_read(8'hFF, 2, "rd_seq_wrap");

      // Half a data byte must not reach memory.
      strobe_q.delete();
      start_x();
      send_hdr(8'h02, 8'h20);
      for (int i = 0; i < 4; i++) spi_bit(1'b1);
      end_x();
      chk("partial_no_strobe", 32'(strobe_q.size()), 32'h0);
      do_read(8'h20, 1, "rd_partial");

      start_x();
      spi_byte(8'h9F);
      spi_byte(8'hFF);
      chk("unk_miso_0", 32'(last_rx), 32'h0);
      spi_byte(8'hFF);
      chk("unk_miso_1", 32'(last_rx), 32'h0);
      end_x();
      chk("unk_mode", 32'(bus.mode), 32'(mode_m));

      for (int r = 0; r < 12; r++) begin
         m = $urandom_range(0, 2);
         do_wrmr((m == 0) ? 8'h00 : (m == 1) ? 8'h40 : 8'h80);
         a = $urandom_range(0, 255);
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
         do_write(a, n);
         do_read(a, n, "rd_rand");
      end

      do_wrmr(8'h80);
      do_wrmr(8'hC0);

      // Reset in the middle of a read data byte.
      start_x();
      send_hdr(8'h03, 8'h10);
      bus.spi_mosi = 1'b0;
      tick(3);
      chk("mid_rd_bit7", 32'(bus.spi_miso), 32'(mem_m[8'h10] >> 7));
      rst_n = 1'b0;
      tick(1);
      chk("mid_rst_miso", 32'(bus.spi_miso), 32'h0);
      chk("mid_rst_mode", 32'(bus.mode), 32'h1);
      rst_n = 1'b1;
      bus.spi_ce = 1'b1;
      tick(4);
      mode_m = 2'b01;
      do_read(8'h10, 2, "rd_after_rst");
      do_read(8'h1F, 1, "rd_keep_1f");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
